// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes D = a - b - bin (mod 2^WIDTH) and the borrow-out B,
// processing one bit per clock, LSB first.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous, active-high reset
//   start - begin a subtraction (accepted in IDLE or DONE, ignored while busy)
//   a, b  - minuend and subtrahend, WIDTH bits
//   bin   - borrow-in
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when D/B have just been updated
//   D     - difference, held until the next completed operation
//   B     - borrow-out (a < b + bin, unsigned), held like D
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             B
);

  // Counter must hold 0..WIDTH-1 without wrapping; at least one bit wide.
  localparam int unsigned CntW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic             a_bit, b_bit, d_bit, br_next;
  logic [WIDTH-1:0] res_upd;

  // Single-bit full-subtractor slice on the bit selected by the counter.
  always_comb begin
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cnt_q == CntW'(i)) begin
        a_bit = a_q[i];
        b_bit = b_q[i];
      end
    end
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_upd = res_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cnt_q == CntW'(i)) begin
        res_upd[i] = d_bit;
      end
    end
  end

  // State register plus datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = start ? StRun : StIdle;
      StRun:          if (cnt_q == LastBit) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Datapath next-state: operands are only sampled when an operation is accepted.
  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    res_d  = res_q;
    diff_d = diff_q;
    br_d   = br_q;
    bout_d = bout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          br_d  = bin;
          cnt_d = '0;
          res_d = '0;
        end
      end
      StRun: begin
        br_d  = br_next;
        res_d = res_upd;
        if (cnt_q == LastBit) begin
          // Publish on the edge that enters DONE; D/B stay frozen during RUN.
          diff_d = res_upd;
          bout_d = br_next;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    D    = diff_q;
    B    = bout_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bo8;
  logic [7:0] a8, b8, d8;
  logic       start1, bin1, busy1, done1, bo1;
  logic [0:0] a1, b1, d1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] last_d8 = '0;
  logic       last_b8 = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .D     (d8),
    .B     (bo8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .bin   (bin1),
    .busy  (busy1),
    .done  (done1),
    .D     (d1),
    .B     (bo1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic one bit wider; the top bit is the borrow.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  function automatic logic [1:0] ref1(input logic x, input logic y, input logic c);
    return {1'b0, x} - {1'b0, y} - {1'b0, c};
  endfunction

  // One WIDTH=8 operation. glitch>0: pulse start with junk operands after edge n=glitch.
  // rst_at>0: assert reset after edge n=rst_at (aborting the run).
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                     input int glitch, input int rst_at);
    logic [8:0] exp;
    int         busy_n;
    int         done_n;
    bit         aborted;
    exp     = ref8(ta, tb, tbin);
    busy_n  = 0;
    done_n  = 0;
    aborted = 0;
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (aborted) begin
        check_eq("no_done_after_rst", 32'(done8), 32'(0));
        check_eq("idle_after_rst", 32'(busy8), 32'(0));
      end else if (rst_at > 0 && n == rst_at + 1) begin
        check_eq("rst_busy", 32'(busy8), 32'(0));
        check_eq("rst_done", 32'(done8), 32'(0));
        check_eq("rst_D", 32'(d8), 32'(0));
        check_eq("rst_B", 32'(bo8), 32'(0));
        aborted = 1;
        last_d8 = '0;
        last_b8 = 1'b0;
      end else begin
        if (busy8) busy_n++;
        if (done8) begin
          done_n++;
          if (done_n == 1) check_eq("latency8", 32'(n), 32'(9));
          check_eq("D8", 32'(d8), 32'(exp[7:0]));
          check_eq("B8", 32'(bo8), 32'(exp[8]));
          last_d8 = exp[7:0];
          last_b8 = exp[8];
        end else begin
          check_eq("D8_hold", 32'(d8), 32'(last_d8));
          check_eq("B8_hold", 32'(bo8), 32'(last_b8));
        end
      end
      start8 = (n == glitch);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      bin8   = 1'($urandom);
      rst    = (rst_at > 0 && n == rst_at);
    end
    if (!aborted) begin
      check_eq("done_count8", 32'(done_n), 32'(1));
      check_eq("busy_cycles8", 32'(busy_n), 32'(8));
    end
  endtask

  // Two operations with start held high through the first DONE.
  task automatic b2b8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input logic [7:0] ya, input logic [7:0] yb, input logic yc);
    logic [8:0] e1, e2;
    int         t1, t2;
    int         done_n;
    e1 = ref8(xa, xb, xc);
    e2 = ref8(ya, yb, yc);
    t1 = 0; t2 = 0; done_n = 0;
    a8 = xa; b8 = xb; bin8 = xc; start8 = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        a8 = ya; b8 = yb; bin8 = yc;
      end
      if (t1 > 0 && n == t1 + 1) begin
        check_eq("b2b_no_idle", 32'(busy8), 32'(1));
        start8 = 1'b0;
      end
      if (done8) begin
        done_n++;
        if (done_n == 1) begin
          t1 = n;
          check_eq("b2b_D1", 32'(d8), 32'(e1[7:0]));
          check_eq("b2b_B1", 32'(bo8), 32'(e1[8]));
        end else begin
          t2 = n;
          check_eq("b2b_D2", 32'(d8), 32'(e2[7:0]));
          check_eq("b2b_B2", 32'(bo8), 32'(e2[8]));
        end
      end
    end
    start8 = 1'b0;
    check_eq("b2b_done_count", 32'(done_n), 32'(2));
    check_eq("b2b_first_latency", 32'(t1), 32'(9));
    check_eq("b2b_gap", 32'(t2 - t1), 32'(9));
    last_d8 = e2[7:0];
    last_b8 = e2[8];
  endtask

  task automatic op1(input logic ta, input logic tb, input logic tc);
    logic [1:0] exp;
    int         done_n;
    exp    = ref1(ta, tb, tc);
    done_n = 0;
    a1 = ta; b1 = tb; bin1 = tc; start1 = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1) begin
        done_n++;
        check_eq("latency1", 32'(n), 32'(2));
        check_eq("D1", 32'(d1), 32'(exp[0]));
        check_eq("B1", 32'(bo1), 32'(exp[1]));
      end
    end
    check_eq("done_count1", 32'(done_n), 32'(1));
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'(busy8), 32'(0));
    check_eq("reset_done", 32'(done8), 32'(0));
    check_eq("reset_D", 32'(d8), 32'(0));
    check_eq("reset_B", 32'(bo8), 32'(0));
    rst = 1'b0;

    op8(8'h05, 8'h03, 1'b0, 0, 0);
    op8(8'h03, 8'h05, 1'b0, 0, 0);
    op8(8'h00, 8'h00, 1'b1, 0, 0);
    op8(8'hA7, 8'h3C, 1'b1, 3, 0);   // mid-run start must be ignored
    op8(8'h81, 8'h12, 1'b0, 0, 4);   // reset mid-run
    op8(8'h42, 8'h42, 1'b1, 0, 0);   // completes normally after the abort
    op8(8'hFF, 8'hFF, 1'b0, 0, 0);
    b2b8(8'h10, 8'h01, 1'b0, 8'h01, 8'h10, 1'b1);

    for (int k = 0; k < 40; k++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0, 0);
    end

    for (int p = 0; p < 8; p++) begin
      logic [2:0] v;
      v = 3'(p);
      op1(v[1], v[0], v[2]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
